// File: rtl/mult4b_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult4b_seq_ctrl.sv
//
// Sequential unsigned 4x4 multiplier controller. It forms an 8-bit product
// by shift-and-add and performs one addition per clock through a single
// adder4b instance, so that adder is shared across all four iterations.
//
// Modules in this file:
//   adder4b          - 4-bit unsigned adder, 5-bit sum with the carry as MSB
//   mult4b_seq_ctrl  - start/done sequenced multiplier (top)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adder4b
//
// Purely combinational 4-bit adder. The carry is kept as the fifth bit so
// the caller never loses the overflow.
//
// Ports:
//   A  input  [3:0]  addend
//   B  input  [3:0]  addend
//   S  output [4:0]  {carry, sum}
// ---------------------------------------------------------------------------
module adder4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [4:0] S
);

    logic [4:0] carry;

    // Explicit ripple chain so the carry-out is visible bit by bit.
    always_comb begin
        carry[0] = 1'b0;
        S        = 5'd0;
        for (int i = 0; i < 4; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
        S[4] = carry[4];
    end

endmodule

// ---------------------------------------------------------------------------
// mult4b_seq_ctrl
//
// State table:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; A and B are captured on the accepting edge
//   ST_CALC | one shift-and-add iteration per edge, four iterations total
//   ST_DONE | done pulse for one cycle, P valid; returns to ST_IDLE
//
// Ports:
//   clock    input         system clock, rising edge active
//   reset_n  input         asynchronous reset, active-low
//   start    input         multiply request, only looked at in ST_IDLE
//   A        input  [3:0]  multiplicand
//   B        input  [3:0]  multiplier
//   busy     output        high while in ST_CALC (registered)
//   done     output        one-cycle completion pulse (registered)
//   P        output [7:0]  product; updated only on entry to ST_DONE
// ---------------------------------------------------------------------------
module mult4b_seq_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] P
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;

    logic [3:0] m;      // latched multiplicand
    logic [3:0] h;      // high accumulator
    logic [3:0] q;      // multiplier, shifted out as the low product fills in
    logic [1:0] cnt;    // iteration counter

    logic [4:0] sum;    // {carry, h + m} from the shared adder
    logic [4:0] acc;    // {carry, h'} for the current iteration

    adder4b u_adder (
        .A (h),
        .B (m),
        .S (sum)
    );

    // Only add the multiplicand when the current multiplier bit is set;
    // otherwise the accumulator passes through with a zero carry.
    always_comb begin
        acc = {1'b0, h};
        if (q[0]) begin
            acc = sum;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= 8'h00;
            m     <= 4'h0;
            h     <= 4'h0;
            q     <= 4'h0;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= A;
                        q     <= B;
                        h     <= 4'h0;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    // {h, q} <= {c, h', q[3:1]}: the 9-bit value shifted right
                    // by one, dropping the consumed multiplier bit.
                    h   <= acc[4:1];
                    q   <= {acc[0], q[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // Last iteration: capture the freshly shifted pair so
                        // P is valid in the same cycle done goes high.
                        P     <= {acc, q[3:1]};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // start is deliberately ignored here; a held start is
                    // re-accepted once back in ST_IDLE.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4b_seq_ctrl.sv
module tb_mult4b_seq_ctrl;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int checks;
    int errors;
    int cyc;

    mult4b_seq_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .P       (P)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch one multiply, wait (bounded) for done, then step back into IDLE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] prod, output int busy_cycles,
                          output bit got, output logic done_after);
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start       = 1'b0;
        busy_cycles = 0;
        got         = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            step();
        end
        prod = P;
        step();
        done_after = done;
    endtask

    logic [7:0] prod;
    int         bc;
    bit         got;
    logic       dtail;
    int         t1;
    int         t2;
    bit         seen;

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_n = 1'b1;
        start   = 1'b0;
        A       = 4'h0;
        B       = 4'h0;

        // Asynchronous reset asserted away from any clock edge.
        #3 reset_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_p", {24'd0, P}, 32'd0);
        #20 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("idle_no_activity", {31'd0, seen}, 32'd0);

        // 5 x 3
        run_op(4'h5, 4'h3, prod, bc, got, dtail);
        chk("op53_got_done", {31'd0, got}, 32'd1);
        chk("op53_busy_cycles", bc, 32'd4);
        chk("op53_p", {24'd0, prod}, 32'h0F);
        chk("op53_done_one_cycle", {31'd0, dtail}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("op53_p_hold", {24'd0, P}, 32'h0F);

        // Carry and shift boundaries
        run_op(4'hF, 4'hF, prod, bc, got, dtail);
        chk("opFF_p", {24'd0, prod}, 32'hE1);
        chk("opFF_busy_cycles", bc, 32'd4);
        run_op(4'h0, 4'h9, prod, bc, got, dtail);
        chk("op09_p", {24'd0, prod}, 32'h00);
        chk("op09_got_done", {31'd0, got}, 32'd1);
        run_op(4'h8, 4'h1, prod, bc, got, dtail);
        chk("op81_p", {24'd0, prod}, 32'h08);

        // start held high; A changed mid-operation
        A     = 4'h2;
        B     = 4'h7;
        start = 1'b1;
        step();
        t1 = cyc;
        chk("held_busy", {31'd0, busy}, 32'd1);
        A = 4'h9;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("held_got_done", {31'd0, got}, 32'd1);
        chk("held_first_p", {24'd0, P}, 32'h0E);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        t2 = cyc;
        chk("held_second_accept", {31'd0, got}, 32'd1);
        chk("held_period", t2 - t1, 32'd6);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("held_second_done", {31'd0, got}, 32'd1);
        chk("held_second_p", {24'd0, P}, 32'h3F);
        step();

        // Abort F x F during the third CALC cycle
        A     = 4'hF;
        B     = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_p", {24'd0, P}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        #12 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_p_after", {24'd0, P}, 32'h00);
        run_op(4'h3, 4'h3, prod, bc, got, dtail);
        chk("op33_p", {24'd0, prod}, 32'h09);

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a[3:0], b[3:0], prod, bc, got, dtail);
                chk($sformatf("sweep_a%0d_b%0d", a, b), {23'd0, ~got, prod}, a * b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
